ascon_perm_ctrl: RTL
====================

ASCON_PERM_CTRL -- requirements
Module: ascon_perm_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  UROL, 1, rounds the masked permutation computes per update.
  SBOX_LATENCY, 2, extra pipeline cycles of the masked S-box per update.
  STALL_W, 16, width of the stall performance counter.
REQ-002 Ports SHALL be, one per line: name direction width meaning.
  clk  in  1  sole clock.
  rst  in  1  asynchronous, active-high reset.
  start  in  1  request to run a permutation.
  start_rounds  in  4  number of rounds requested (ROUNDS_A=12 or ROUNDS_B=6 in normal use).
  start_ready  out  1  controller idle, start accepted.
  abort  in  1  synchronous cancel of the running permutation.
  rnd_req  out  1  fresh-randomness request for the current S-box cycle.
  rnd_valid  in  1  PRNG supplies fresh randomness this cycle.
  round_cnt  out  4  remaining rounds, driven to the asconp round-constant input.
  state_we  out  1  capture permutation output into the share state registers.
  busy  out  1  permutation in progress.
  done  out  1  one-cycle pulse, permutation complete.
  err  out  1  one-cycle pulse, illegal start_rounds rejected.
  stall_cnt  out  STALL_W  saturating count of randomness-stall cycles.
REQ-003 There SHALL be one clock, clk; reset rst SHALL be asynchronous and active-high.

Function
REQ-004 FSM states SHALL be IDLE, RUN and DONE.
REQ-005 A start SHALL be accepted when start & start_ready; start_ready = (fsm==IDLE).
REQ-006 The start_rounds value SHALL be legal when it is nonzero, <=12 and a multiple of UROL.
REQ-007 An accepted start with legal start_rounds SHALL load round_cnt<=start_rounds and sbox_cnt<=SBOX_LATENCY, then move to RUN.
REQ-008 An accepted start with illegal start_rounds SHALL pulse err for one cycle and keep the FSM in IDLE.
REQ-009 In RUN, rnd_req SHALL be 1 every cycle and busy SHALL be 1.
REQ-010 In RUN with rnd_valid=0, the controller SHALL stall: sbox_cnt, round_cnt and state_we held at their current values, state_we=0, stall_cnt incremented.
REQ-011 In RUN with rnd_valid=1 and sbox_cnt!=0, sbox_cnt SHALL decrement by 1.
REQ-012 In RUN with rnd_valid=1 and sbox_cnt==0, the controller SHALL assert state_we=1 and set round_cnt<=round_cnt-UROL.
REQ-013 After the update in REQ-012, the FSM SHALL go to DONE if the result is 0; otherwise sbox_cnt SHALL reload to SBOX_LATENCY.
REQ-014 In DONE, done SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE; busy=0 and rnd_req=0 in DONE.
REQ-015 Latency: with rnd_valid held at 1, done SHALL assert exactly start_rounds/UROL*(SBOX_LATENCY+1)+1 cycles after the accept edge.
REQ-016 abort=1 in RUN or DONE SHALL force IDLE on the next edge with no done pulse and no state_we that cycle; abort has priority over rnd_valid.
REQ-017 abort in IDLE SHALL have no effect.
REQ-018 start while not in IDLE SHALL be ignored and SHALL NOT be queued.
REQ-019 stall_cnt SHALL saturate at all-ones and SHALL clear only on reset.
REQ-020 round_cnt SHALL hold its last value while in IDLE.
REQ-021 Outputs done, err and state_we SHALL be registered-state decodes, free of combinational paths from start.

Reset
REQ-022 Asserting rst at any time, including mid-RUN, SHALL immediately force fsm=IDLE.
REQ-023 Under rst, outputs SHALL take these values: round_cnt=0, sbox_cnt=0, stall_cnt=0, start_ready=1, busy=0, done=0, err=0, state_we=0, rnd_req=0.

Structure
REQ-024 The constants ROUNDS_A, ROUNDS_B, UROL and SBOX_LATENCY SHALL come from the shared core configuration header; the FSM enum type SHALL live in the shared sca package.
REQ-025 The block SHALL be a single module with no sub-module; stall-counter saturation SHALL be inline logic.

Verification
REQ-026 Start with rounds=12, UROL=1, SBOX_LATENCY=2, rnd_valid=1 -> state_we at cycles 3,6,...,36 with round_cnt 12->0, and done at cycle 37.
REQ-027 Start with rounds=6 and rnd_valid low for 5 cycles mid-run -> done delayed by exactly 5 cycles and stall_cnt=5.
REQ-028 Start with rounds=0, then rounds=13 -> one err pulse each, FSM stays IDLE, no rnd_req.
REQ-029 abort on the cycle where sbox_cnt==0 and rnd_valid=1 -> no state_we and no done, start_ready=1 on the next cycle.
REQ-030 rst asserted mid-RUN, then released, then start rounds=6 -> immediate IDLE with outputs as in REQ-023, and a clean 19-cycle run.
REQ-031 A second start during RUN -> ignored; exactly one done pulse.

Source files
------------

// File: rtl/ascon_perm_ctrl_pkg.sv
// Shared core configuration and FSM type for the masked Ascon permutation
// controller: round counts, unroll factor, S-box latency and the legality check.
package ascon_perm_ctrl_pkg;

    localparam int ROUNDS_A         = 12;
    localparam int ROUNDS_B         = 6;
    localparam int CFG_UROL         = 1;
    localparam int CFG_SBOX_LATENCY = 2;
    localparam int MAX_ROUNDS       = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_e;

    // A round request is usable only if the unrolled datapath can finish it exactly.
    function automatic logic rounds_legal(input logic [3:0] rounds, input int urol);
        return (rounds != 4'd0) &&
               (int'(rounds) <= MAX_ROUNDS) &&
               ((int'(rounds) % urol) == 0);
    endfunction

endpackage

// File: rtl/ascon_perm_ctrl.sv
// Round/S-box sequencing for a masked Ascon permutation: waits on fresh
// randomness every S-box cycle, counts stalls, supports abort and rejects bad round counts.
module ascon_perm_ctrl
    import ascon_perm_ctrl_pkg::*;
#(
    parameter int UROL         = CFG_UROL,
    parameter int SBOX_LATENCY = CFG_SBOX_LATENCY,
    parameter int STALL_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [3:0]         start_rounds,
    output logic               start_ready,
    input  logic               abort,
    output logic               rnd_req,
    input  logic               rnd_valid,
    output logic [3:0]         round_cnt,
    output logic               state_we,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [STALL_W-1:0] stall_cnt
);

    localparam int                SBOX_W    = (SBOX_LATENCY < 1) ? 1 : $clog2(SBOX_LATENCY + 1);
    localparam logic [SBOX_W-1:0] SBOX_LOAD = SBOX_W'(SBOX_LATENCY);
    localparam logic [3:0]        UROL_STEP = 4'(UROL);
    localparam logic [STALL_W-1:0] STALL_MAX = {STALL_W{1'b1}};
    localparam logic [STALL_W-1:0] STALL_ONE = {{(STALL_W-1){1'b0}}, 1'b1};

    fsm_e               fsm, fsm_next;
    logic [SBOX_W-1:0]  sbox_cnt, sbox_next;
    logic [3:0]         round_next;
    logic [STALL_W-1:0] stall_next;
    logic               err_r, err_next;

    // State, counters and the err flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm       <= IDLE;
            sbox_cnt  <= {SBOX_W{1'b0}};
            round_cnt <= 4'd0;
            stall_cnt <= {STALL_W{1'b0}};
            err_r     <= 1'b0;
        end else begin
            fsm       <= fsm_next;
            sbox_cnt  <= sbox_next;
            round_cnt <= round_next;
            stall_cnt <= stall_next;
            err_r     <= err_next;
        end
    end

    // Next-state logic; state_we and done are decodes of the current state
    // qualified by rnd_valid/abort, so an abort suppresses both in the same cycle.
    always_comb begin
        fsm_next   = fsm;
        sbox_next  = sbox_cnt;
        round_next = round_cnt;
        stall_next = stall_cnt;
        err_next   = 1'b0;
        state_we   = 1'b0;
        done       = 1'b0;
        case (fsm)
            IDLE: begin
                if (start) begin
                    if (rounds_legal(start_rounds, UROL)) begin
                        round_next = start_rounds;
                        sbox_next  = SBOX_LOAD;
                        fsm_next   = RUN;
                    end else begin
                        err_next = 1'b1;
                    end
                end else begin
                    fsm_next = IDLE;
                end
            end
            RUN: begin
                if (abort) begin
                    fsm_next = IDLE;
                end else if (!rnd_valid) begin
                    if (stall_cnt != STALL_MAX) begin
                        stall_next = stall_cnt + STALL_ONE;
                    end else begin
                        stall_next = stall_cnt;
                    end
                end else if (sbox_cnt != {SBOX_W{1'b0}}) begin
                    sbox_next = sbox_cnt - {{(SBOX_W-1){1'b0}}, 1'b1};
                end else begin
                    state_we   = 1'b1;
                    round_next = round_cnt - UROL_STEP;
                    if (round_next == 4'd0) begin
                        fsm_next = DONE;
                    end else begin
                        sbox_next = SBOX_LOAD;
                    end
                end
            end
            DONE: begin
                fsm_next = IDLE;
                done     = !abort;
            end
            default: begin
                fsm_next = IDLE;
            end
        endcase
    end

    assign start_ready = (fsm == IDLE);
    assign busy        = (fsm == RUN);
    assign rnd_req     = (fsm == RUN);
    assign err         = err_r;

endmodule
